// File: rtl/gpr_wb_sched.sv
// Write-port scheduler for the GPR/control-register bank: arbitrates the trap save
// sequence, the EX result and a 2-entry load-return FIFO onto one write port.
module gpr_wb_sched #(
   parameter logic [6:0] IDLE_ID = 7'h7F,
   parameter logic [6:0] SSR_ID  = 7'h5C,
   parameter logic [6:0] SPC_ID  = 7'h5D,
   parameter logic [6:0] SGR_ID  = 7'h53
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        exWrValid,
   input  logic [6:0]  exWrId,
   input  logic [31:0] exWrVal,
   input  logic        memWrValid,
   input  logic [6:0]  memWrId,
   input  logic [31:0] memWrVal,
   output logic        memWrReady,
   input  logic        trapReq,
   input  logic [31:0] trapSr,
   input  logic [31:0] trapPc,
   input  logic [31:0] trapSp,
   output logic        trapBusy,
   output logic        trapDone,
   input  logic        rbToggle,
   output logic [6:0]  regIdRo,
   output logic [31:0] regValRo,
   output logic        exHold,
   output logic [1:0]  o_dbg_state,
   output logic [1:0]  o_dbg_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SSR  = 2'd1,
      ST_SPC  = 2'd2,
      ST_SGR  = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_sr;
   logic [31:0] r_pc;
   logic [31:0] r_sp;
   logic [6:0]  r_fifo_id  [2];
   logic [31:0] r_fifo_val [2];
   logic [1:0]  r_count;

   logic w_idle;
   logic w_waw;
   logic w_ex_issue;
   logic w_pop;
   logic w_push;
   logic w_ready;
   logic w_push_slot;

   assign w_idle = (r_state == ST_IDLE);

   // An older load to the same register must reach the bank before the EX write.
   assign w_waw = ((r_count != 2'd0) && (r_fifo_id[0] == exWrId)) ||
                  ((r_count == 2'd2) && (r_fifo_id[1] == exWrId));

   assign w_ex_issue = !reset && exWrValid && w_idle && !w_waw &&
                       !(rbToggle && (exWrId[6:3] == 4'd0));

   assign w_pop = !reset && (r_count != 2'd0) && w_idle && !w_ex_issue &&
                  !(rbToggle && (r_fifo_id[0][6:3] == 4'd0));

   assign w_ready     = !reset && (r_count < 2'd2);
   assign w_push      = memWrValid && w_ready;
   assign w_push_slot = r_count[0] && !w_pop;

   assign memWrReady  = w_ready;
   assign exHold      = !reset && exWrValid && !w_ex_issue;
   assign trapBusy    = !reset && !w_idle;
   assign trapDone    = !reset && (r_state == ST_SGR);
   assign o_dbg_state = r_state;
   assign o_dbg_count = r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sr    <= 32'd0;
         r_pc    <= 32'd0;
         r_sp    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (trapReq) begin
                  r_sr    <= trapSr;
                  r_pc    <= trapPc;
                  r_sp    <= trapSp;
                  r_state <= ST_SSR;
               end
            end
            ST_SSR:  r_state <= ST_SPC;
            ST_SPC:  r_state <= ST_SGR;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Head lives in slot 0; a pop shifts slot 1 down and a same-cycle push lands behind it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= 2'd0;
      end else begin
         if (w_pop) begin
            r_fifo_id[0]  <= r_fifo_id[1];
            r_fifo_val[0] <= r_fifo_val[1];
         end
         if (w_push) begin
            r_fifo_id[w_push_slot]  <= memWrId;
            r_fifo_val[w_push_slot] <= memWrVal;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_comb begin
      regIdRo  = IDLE_ID;
      regValRo = 32'd0;
      if (!reset) begin
         case (r_state)
            ST_SSR: begin
               regIdRo  = SSR_ID;
               regValRo = r_sr;
            end
            ST_SPC: begin
               regIdRo  = SPC_ID;
               regValRo = r_pc;
            end
            ST_SGR: begin
               regIdRo  = SGR_ID;
               regValRo = r_sp;
            end
            default: begin
               if (w_ex_issue) begin
                  regIdRo  = exWrId;
                  regValRo = exWrVal;
               end else if (w_pop) begin
                  regIdRo  = r_fifo_id[0];
                  regValRo = r_fifo_val[0];
               end
            end
         endcase
      end
   end

endmodule
